// File: rtl/ws2812_strip_driver_if.sv
// Host-side bundle for the WS2812 strip driver: pixel writes, frame request,
// status, the serial line and a state debug view.
interface ws2812_strip_driver_if #(
   parameter int ADDR_W = 6
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [23:0]       wr_data;
   logic [7:0]        brightness;
   logic              start;
   logic              busy;
   logic              done;
   logic              rz_data;
   logic [1:0]        state_dbg;

   // start is a level sampled only in IDLE; done is a single-cycle pulse.
   modport master (
      output wr_en, wr_addr, wr_data, brightness, start,
      input  busy, done, rz_data, state_dbg
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, brightness, start,
      output busy, done, rz_data, state_dbg
   );
endinterface

// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: NUM_LEDS x 24 pixel buffer, global brightness scaling and a
// gapless return-to-zero serialiser (GRB, MSB first) followed by a latch gap.
module ws2812_strip_driver #(
   parameter int NUM_LEDS = 60,
   parameter int T0H      = 17,
   parameter int T1H      = 35,
   parameter int TBIT     = 63,
   parameter int TRESET   = 15000
) (
   input logic                  clk,
   input logic                  rst,
   ws2812_strip_driver_if.slave bus
);
   localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
   localparam int LW = (TRESET > 1) ? $clog2(TRESET) : 1;

   localparam logic [CW-1:0] BIT_LAST = CW'(TBIT - 1);
   localparam logic [CW-1:0] HI_ZERO  = CW'(T0H);
   localparam logic [CW-1:0] HI_ONE   = CW'(T1H);
   localparam logic [AW-1:0] PIX_LAST = AW'(NUM_LEDS - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(TRESET - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_SEND  = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          ph_q, ph_d;
   logic [7:0]    bri_q, bri_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [4:0]    bit_idx_q, bit_idx_d;
   logic [AW-1:0] pix_q, pix_d;
   logic [LW-1:0] lat_q, lat_d;
   logic [23:0]   sh_q, sh_d;
   logic [23:0]   nxt_q, nxt_d;
   logic          rz_q, rz_d;
   logic          done_q, done_d;

   logic [23:0]   mem_q [NUM_LEDS];
   logic [23:0]   rd_q;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          wr_ok;
   logic [23:0]   scaled;

   function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
      return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
   endfunction

   // Stored as RGB, transmitted as GRB.
   assign scaled = {scale_ch(rd_q[15:8], bri_q), scale_ch(rd_q[23:16], bri_q),
                    scale_ch(rd_q[7:0], bri_q)};

   assign wr_ok = 32'(bus.wr_addr) < 32'(NUM_LEDS);

   // Registered read returns pre-write contents on a same-cycle collision.
   always_ff @(posedge clk) begin
      if (bus.wr_en && wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
      if (rd_en) rd_q <= mem_q[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ph_q      <= 1'b0;
         bri_q     <= 8'd0;
         bit_cnt_q <= '0;
         bit_idx_q <= 5'd0;
         pix_q     <= '0;
         lat_q     <= '0;
         sh_q      <= 24'd0;
         nxt_q     <= 24'd0;
         rz_q      <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         bri_q     <= bri_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         pix_q     <= pix_d;
         lat_q     <= lat_d;
         sh_q      <= sh_d;
         nxt_q     <= nxt_d;
         rz_q      <= rz_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      bri_d     = bri_q;
      bit_cnt_d = bit_cnt_q;
      bit_idx_d = bit_idx_q;
      pix_d     = pix_q;
      lat_d     = lat_q;
      sh_d      = sh_q;
      nxt_d     = nxt_q;
      rz_d      = 1'b0;
      done_d    = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_FETCH;
               bri_d   = bus.brightness;
               ph_d    = 1'b0;
               pix_d   = '0;
            end
         end
         S_FETCH: begin
            if (!ph_q) begin
               rd_en = 1'b1;
               ph_d  = 1'b1;
            end else begin
               sh_d      = scaled;
               bit_idx_d = 5'd23;
               bit_cnt_d = '0;
               state_d   = S_SEND;
            end
         end
         S_SEND: begin
            rz_d = bit_cnt_q < (sh_q[23] ? HI_ONE : HI_ZERO);
            // Prefetch and scale the next pixel during the last bit of this one.
            if (bit_idx_q == 5'd0 && bit_cnt_q == '0 && pix_q != PIX_LAST) begin
               rd_en   = 1'b1;
               rd_addr = AW'(pix_q + 1'b1);
            end
            if (bit_idx_q == 5'd0 && bit_cnt_q == CW'(1)) nxt_d = scaled;
            if (bit_cnt_q == BIT_LAST) begin
               bit_cnt_d = '0;
               if (bit_idx_q == 5'd0) begin
                  if (pix_q == PIX_LAST) begin
                     state_d = S_LATCH;
                     lat_d   = '0;
                  end else begin
                     pix_d     = AW'(pix_q + 1'b1);
                     sh_d      = nxt_q;
                     bit_idx_d = 5'd23;
                  end
               end else begin
                  sh_d      = {sh_q[22:0], 1'b0};
                  bit_idx_d = bit_idx_q - 5'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         S_LATCH: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               lat_d   = '0;
            end else begin
               lat_d = lat_q + LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;
   assign bus.rz_data   = rz_q;
   assign bus.state_dbg = state_q;
endmodule
